// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory pipeline.
//   lsu_size_e    : access size encoding, 2^size bytes
//   LSU_IMM_W     : width of the signed address immediate
//   lsu_byte_mask : byte-enable pattern for an access, before lane shifting
package lsu_pkg;

   localparam int unsigned LSU_IMM_W = 12;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   // Byte-enable pattern for an access of the given size, anchored at lane 0
   function automatic logic [7:0] lsu_byte_mask(input lsu_size_e size);
      logic [7:0] mask;
      case (size)
         SZ_B:    mask = 8'h01;
         SZ_H:    mask = 8'h03;
         SZ_W:    mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/lsu_load_queue.sv
// In-order tracking FIFO for outstanding loads.
//   push/push_data : enqueue one entry (ignored when full)
//   pop            : dequeue the head entry (ignored when empty)
//   head_data      : oldest entry
//   full/empty     : occupancy flags
//   count          : occupancy, 0..DEPTH
module lsu_load_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;

   // Pointer/count update; power-of-two depth makes pointer wrap free
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/lsu_mem_pipe.sv
// LSU slot memory backend: effective-address generation, misalignment trap,
// single-entry byte-enabled request register with valid/ready handshake,
// in-order load tracking and load-data alignment/extension for writeback.
//   in_*       : decoded op from ID/EX, accepted on in_valid && in_ready
//   mem_req_*  : request to data memory (held while not ready)
//   mem_rsp_*  : in-order load data, no backpressure
//   wb_*       : one-cycle register-file write
//   misalign_* : one-cycle trap pulse with the faulting effective address
module lsu_mem_pipe
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN            = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned REG_W           = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_is_load,
   input  logic [1:0]           in_size,
   input  logic                 in_zero_ext,
   input  logic [REG_W-1:0]     in_rd,
   input  logic [XLEN-1:0]      in_base,
   input  logic [LSU_IMM_W-1:0] in_imm,
   input  logic [XLEN-1:0]      in_wdata,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic                 mem_req_we,
   output logic [XLEN-1:0]      mem_req_addr,
   output logic [XLEN-1:0]      mem_req_wdata,
   output logic [XLEN/8-1:0]    mem_req_be,
   input  logic                 mem_rsp_valid,
   input  logic [XLEN-1:0]      mem_rsp_rdata,
   output logic                 wb_valid,
   output logic [REG_W-1:0]     wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic                 misalign_valid,
   output logic [XLEN-1:0]      misalign_addr
);

   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      lsu_size_e        size;
      logic             zero_ext;
      logic [OFF_W-1:0] off;
   } lsu_ldq_entry_t;

   localparam int unsigned ENT_W = $bits(lsu_ldq_entry_t);

   // Registered state
   logic              req_valid_q, req_valid_d;
   logic              req_we_q,    req_we_d;
   logic [XLEN-1:0]   req_addr_q,  req_addr_d;
   logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
   logic [BE_W-1:0]   req_be_q,    req_be_d;
   logic              wb_valid_q,  wb_valid_d;
   logic [REG_W-1:0]  wb_rd_q,     wb_rd_d;
   logic [XLEN-1:0]   wb_data_q,   wb_data_d;
   logic              mis_valid_q, mis_valid_d;
   logic [XLEN-1:0]   mis_addr_q,  mis_addr_d;

   // Decode / datapath
   lsu_size_e         size;
   logic [XLEN-1:0]   ea;
   logic [OFF_W-1:0]  off;
   logic [2:0]        align_mask;
   logic              size_ok, misaligned, accept, push;
   logic [3:0]        nbytes;
   logic [BE_W-1:0]   be;
   logic [XLEN-1:0]   wdata_rep;
   lsu_ldq_entry_t    push_ent, head_ent;
   logic [ENT_W-1:0]  head_bits;
   logic              ldq_empty, ldq_full_unused;
   logic [CNT_W-1:0]  ldq_count;
   logic [XLEN-1:0]   rsp_shifted, rsp_ext;
   int unsigned       ld_bits;

   assign size       = lsu_size_e'(in_size);
   assign ea         = in_base + {{(XLEN-LSU_IMM_W){in_imm[LSU_IMM_W-1]}}, in_imm};
   assign off        = ea[OFF_W-1:0];
   assign size_ok    = (XLEN == 64) || (size != SZ_D);
   assign align_mask = 3'((4'd1 << size) - 4'd1);
   assign misaligned = !size_ok || ((ea[2:0] & align_mask) != 3'd0);
   assign nbytes     = 4'd1 << size;
   assign be         = BE_W'(16'(lsu_byte_mask(size)) << off);

   // A pop in the same cycle deliberately does not free a slot for this push
   assign in_ready = (!req_valid_q || mem_req_ready)
                   && (!in_is_load || (ldq_count < CNT_W'(MAX_OUTSTANDING)));
   assign accept   = in_valid && in_ready;
   assign push     = accept && !misaligned && in_is_load;

   // Replicate the low 2^size bytes of store data across every lane
   always_comb begin
      wdata_rep = '0;
      for (int unsigned i = 0; i < BE_W; i++) begin
         wdata_rep[8*i +: 8] = in_wdata[8*(i % 32'(nbytes)) +: 8];
      end
   end

   assign push_ent = '{rd: in_rd, size: size, zero_ext: in_zero_ext, off: off};

   lsu_load_queue #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (ENT_W)
   ) u_ldq (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_ent),
      .pop       (mem_rsp_valid),
      .head_data (head_bits),
      .full      (ldq_full_unused),
      .empty     (ldq_empty),
      .count     (ldq_count)
   );

   assign head_ent = lsu_ldq_entry_t'(head_bits);

   // Align the returning line to the head entry's lane, then extend
   always_comb begin
      rsp_shifted = mem_rsp_rdata >> {head_ent.off, 3'b000};
      ld_bits     = 32'd8 << head_ent.size;
      if (ld_bits > XLEN) begin
         ld_bits = XLEN;
      end
      rsp_ext = '0;
      for (int unsigned b = 0; b < XLEN; b++) begin
         if (b < ld_bits) begin
            rsp_ext[b] = rsp_shifted[b];
         end else begin
            rsp_ext[b] = head_ent.zero_ext ? 1'b0 : rsp_shifted[ld_bits-1];
         end
      end
   end

   // Next-state: request register refills in the cycle it drains
   always_comb begin
      req_valid_d = req_valid_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_be_d    = req_be_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      mis_valid_d = 1'b0;
      mis_addr_d  = mis_addr_q;

      if (mem_req_ready) begin
         req_valid_d = 1'b0;
      end
      if (accept && !misaligned) begin
         req_valid_d = 1'b1;
         req_we_d    = !in_is_load;
         req_addr_d  = {ea[XLEN-1:OFF_W], OFF_W'(0)};
         req_wdata_d = wdata_rep;
         req_be_d    = be;
      end
      if (accept && misaligned) begin
         mis_valid_d = 1'b1;
         mis_addr_d  = ea;
      end
      // Responses with nothing outstanding are dropped
      if (mem_rsp_valid && !ldq_empty) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = head_ent.rd;
         wb_data_d  = rsp_ext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_valid_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_be_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         mis_valid_q <= 1'b0;
         mis_addr_q  <= '0;
      end else begin
         req_valid_q <= req_valid_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_be_q    <= req_be_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         mis_valid_q <= mis_valid_d;
         mis_addr_q  <= mis_addr_d;
      end
   end

   assign mem_req_valid  = req_valid_q;
   assign mem_req_we     = req_we_q;
   assign mem_req_addr   = req_addr_q;
   assign mem_req_wdata  = req_wdata_q;
   assign mem_req_be     = req_be_q;
   assign wb_valid       = wb_valid_q;
   assign wb_rd          = wb_rd_q;
   assign wb_data        = wb_data_q;
   assign misalign_valid = mis_valid_q;
   assign misalign_addr  = mis_addr_q;

endmodule

// File: doc/lsu_mem_pipe.md
# lsu_mem_pipe

Parametrised load/store pipeline backend for the VLIW LSU slot. Accepts decoded memory ops (base, immediate, size, extension mode, destination register) from the ID/EX stage and computes the effective address. Issues byte-enabled requests to data memory over a valid/ready handshake. Tracks up to `MAX_OUTSTANDING` in-order loads, and aligns and extends load responses for register-file writeback. Extends the single-cycle LSU with the following:
- configurable data width
- backpressure
- multiple loads in flight
- misalignment trapping

## Interface
Parameters:
- `XLEN`, 32, data/address width; legal values 32 or 64
- `MAX_OUTSTANDING`, 4, load-tracking queue depth (power of two, ≥2)
- `REG_W`, 5, register index width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  op presented
- `in_ready`  out  1  op accepted when `in_valid && in_ready`
- `in_is_load`  in  1  1 = load, 0 = store
- `in_size`  in  2  access is 2^size bytes
- `in_zero_ext`  in  1  load zero-extends (else sign-extends)
- `in_rd`  in  REG_W  load destination
- `in_base`  in  XLEN  rs1 data
- `in_imm`  in  12  signed offset
- `in_wdata`  in  XLEN  rs2 data (stores)
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  memory accepts
- `mem_req_we`  out  1  store
- `mem_req_addr`  out  XLEN  aligned-down address (low log2(XLEN/8) bits zero)
- `mem_req_wdata`  out  XLEN  lane-replicated store data
- `mem_req_be`  out  XLEN/8  byte enables
- `mem_rsp_valid`  in  1  load data returning, in request order, no backpressure
- `mem_rsp_rdata`  in  XLEN  full-width line
- `wb_valid`  out  1  register write
- `wb_rd`  out  REG_W  destination
- `wb_data`  out  XLEN  extended load data
- `misalign_valid`  out  1  one-cycle trap pulse
- `misalign_addr`  out  XLEN  faulting effective address

## Operation
- EA = `in_base` + sign_extend(`in_imm`), modulo 2^XLEN.
- Legal size: 2^size ≤ XLEN/8; size 3 is illegal for XLEN=32.
- Misaligned: EA not a multiple of 2^size, or size illegal.
  - Op is accepted but never reaches memory and never enters the queue.
  - `misalign_valid`/`misalign_addr` are registered for one cycle.
- Byte offset `off` = EA mod (XLEN/8).
- `mem_req_be` = (2^(2^size) − 1) << `off`.
- `mem_req_wdata` = low 2^size bytes of `in_wdata`, replicated across all lanes.
- Request register is a single entry. It holds while `mem_req_valid && !mem_req_ready`, and it may be refilled in the same cycle it drains.
- `in_ready` = (!`mem_req_valid` || `mem_req_ready`) && (!`in_is_load` || `count` < `MAX_OUTSTANDING`).
  - A pop in the same cycle does not free a slot for that cycle's push.
- Load queue entry = {rd, size, zero_ext, off}.
  - Push on acceptance of an aligned load; pop on `mem_rsp_valid`.
  - Pointers wrap modulo `MAX_OUTSTANDING`.
  - `count` runs 0..`MAX_OUTSTANDING`.
- Simultaneous push and pop: `count` unchanged and both pointers advance.
- Response with the queue empty: dropped; no writeback and no state change.
- Writeback data = (`mem_rsp_rdata` >> 8·off) truncated to 2^size bytes, then zero- or sign-extended per `zero_ext`. Full-width loads pass through unchanged.
- Stores produce no writeback.
- Reset (any time, including mid-transaction):
  - queue emptied, pointers 0
  - all outputs 0 (`mem_req_valid`, `wb_valid`, `misalign_valid`, data/addr buses)
  - `in_ready` then follows its equation
  - responses to pre-reset requests arriving afterwards are dropped as unexpected

## Timing
- Accept at cycle t → `mem_req_valid` at t+1; held until the handshake completes.
- Misalign: accept at t → pulse at t+1 only.
- `mem_rsp_valid` at r → `wb_valid` at r+1 for exactly one cycle.
- Back-to-back accepts at 1 op/cycle while `mem_req_ready`=1 and the queue is not full.
- No combinational path from `mem_rsp_*` to `mem_req_*` or `in_ready`.

## Structure
- `lsu_pkg` holds:
  - `lsu_size_e` (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`)
  - `lsu_ldq_entry_t` packed struct (width depends on parameters, so declared via parameterised typedef macro or local to the module)
  - immediate width constant `LSU_IMM_W`=12
- Sub-module `lsu_load_queue`: parametrised FIFO with push, pop, full, empty and count outputs, and head data. All other logic stays in the top.

## Test plan
- XLEN=32, base=0x1000, imm=−4, size=W store, wdata=0xDEADBEEF → req addr 0x0FFC, be=4'b1111, we=1, one cycle after accept.
- Load byte: EA=0x1003, sign-extended, rsp=0x80XXXXXX → wb_data=0xFFFFFF80. The same load zero-extended → 0x00000080.
- Halfword at EA=0x2001 → `misalign_valid` pulse with addr 0x2001; no `mem_req_valid`, no queue push. XLEN=32 with size 3 → trap.
- Fill 4 loads with `mem_req_ready`=1 and responses withheld → `in_ready`=0 for a 5th load while stores still issue. Responses 0x11, 0x22, 0x33, 0x44 → wb to rd 1..4 in order.
- `mem_req_ready` held 0 for 3 cycles → request fields stable and `in_ready`=0. Release → request drains and the next op loads in the same cycle.
- Assert `rst` with 2 loads outstanding → all outputs 0 and count 0. A later `mem_rsp_valid` → no `wb_valid`.
